maze_episode_ctrl: RTL
======================

// Module: maze_episode_ctrl
// PURPOSE
//  Sequences Q-learning episodes on the 5x5 maze (states 1..25). Each step: choose an action
//  (epsilon-greedy: 8-bit LFSR vs Q-table best action), drive the external combinational
//  state selector, and hand a (state, action, next_state, reward) tuple to the Q-update unit
//  over a valid/ready handshake. Ends episodes on goal or step limit; runs N_EPISODES per start.
// PARAMETERS
//  MAX_STEPS   64   step limit per episode (1..255)
//  N_EPISODES  100  episodes per run (1..65535)
//  LFSR_SEED   8'hA5  LFSR value after reset; must be nonzero
// PORTS
//  clk             in   1  single clock, rising edge
//  rst             in   1  synchronous, active-high reset
//  start           in   1  begin run; sampled in IDLE/DONE only, ignored while busy
//  start_state     in   6  initial state each episode; 0 or >25 is replaced by 1
//  goal_state      in   6  terminal state
//  explore_thresh  in   8  epsilon: explore when lfsr < explore_thresh
//  q_best_action   in   4  argmax action for ss_current_state (from the Q-table)
//  ss_current_state out 6  to selector current_state
//  ss_action       out  4  to selector next_action (0 = no move)
//  ss_next_state   in   6  from selector next_state
//  upd_valid       out  1  update tuple valid
//  upd_ready       in   1  Q-update unit accepts
//  upd_state/upd_next_state out 6; upd_action out 4; upd_reward out 8 signed
//  busy            out  1  high from INIT through the last CHECK
//  ep_done         out  1  one-cycle pulse at episode end
//  ep_goal         out  1  with ep_done: episode reached goal
//  ep_steps        out  8  steps of the finished episode (valid with ep_done)
//  ep_index        out 16  episodes completed in current run
//  run_done        out  1  level, high in DONE
// BEHAVIOUR
//  Reset: state IDLE; cur_state=1; ss_action=0; upd_valid/busy/ep_done/ep_goal/run_done=0;
//   ep_steps=0; ep_index=0; lfsr=LFSR_SEED. Reset mid-operation aborts at once; upd_valid
//   is 0 in the cycle after rst, even during an unfinished handshake.
//  LFSR: Fibonacci, x^8+x^6+x^5+x^4+1, advances every cycle after reset.
//  FSM: IDLE -start-> INIT (ep_index=0) -> SELECT -> MOVE -> UPDATE -> CHECK -> SELECT|INIT|DONE.
//   INIT: cur_state<=sanitised start_state, step_cnt<=0.
//   SELECT: act<= (lfsr<explore_thresh || q_best_action not in 1..4) ? lfsr[1:0]+1 : q_best_action.
//   MOVE: ss_action=act, ss_current_state=cur_state; nxt<=ss_next_state;
//    reward<= (ss_next_state==goal_state) ? +100 : -1.
//   UPDATE: upd_valid=1, payload held stable until upd_valid&&upd_ready; on handshake
//    cur_state<=nxt, step_cnt+1, upd_valid drops next cycle.
//   CHECK: if cur_state==goal_state or step_cnt==MAX_STEPS: ep_done pulse, ep_goal, ep_steps,
//    ep_index+1; if ep_index+1==N_EPISODES -> DONE else INIT. Otherwise -> SELECT.
//   DONE: run_done=1; start -> INIT (counters cleared), busy=1.
//  Latency: 4 cycles/step with upd_ready tied high; upd_ready stalls add cycles 1:1.
//  start_state==goal_state: first move still taken (goal checked only in CHECK).
//  ss_action=0 outside MOVE; ss_current_state always shows cur_state.
// STRUCTURE
//  maze_pkg: GRID_W=5, N_STATES=25; ACT_NONE=0, ACT_RIGHT=1, ACT_UP=2, ACT_LEFT=3,
//   ACT_DOWN=4; REWARD_GOAL=8'sd100, REWARD_STEP=-8'sd1; FSM state enum.
//  Sub-module: maze_lfsr8 (seed parameter, enable, 8-bit out). State selector instantiated
//  by the parent, not inside this block.
// TESTING
//  1 Reset: rst high 2 cycles -> all outputs at reset values, ss_current_state=1, ss_action=0.
//  2 Greedy path: thresh=0, q_best=1, start=1, goal=5, ready=1 -> tuples (1,1,2,-1),(2,1,3,-1),
//    (3,1,4,-1),(4,1,5,+100); ep_done with ep_steps=4, ep_goal=1; 4 cycles per step.
//  3 Step limit: MAX_STEPS=8, thresh=0, q_best=3, start=1, goal=25 -> 8 tuples (1,3,1,-1);
//    ep_done with ep_steps=8, ep_goal=0.
//  4 Backpressure: ready low 5 cycles in UPDATE -> upd_valid held, payload stable,
//    cur_state unchanged; advance exactly once when ready rises.
//  5 Explore: thresh=255 or q_best=0 -> all upd_action in 1..4, sequence matches LFSR model.
//  6 Run/abort: N_EPISODES=3 -> 3 ep_done pulses, ep_index 3, run_done=1; rst during UPDATE ->
//    IDLE and upd_valid=0 next cycle.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared constants, FSM encoding and small helpers for the 5x5 maze Q-learning controller.
package maze_pkg;

   localparam int GRID_W   = 5;
   localparam int N_STATES = GRID_W * GRID_W;

   localparam logic [3:0] ACT_NONE  = 4'd0;
   localparam logic [3:0] ACT_RIGHT = 4'd1;
   localparam logic [3:0] ACT_UP    = 4'd2;
   localparam logic [3:0] ACT_LEFT  = 4'd3;
   localparam logic [3:0] ACT_DOWN  = 4'd4;

   localparam logic signed [7:0] REWARD_GOAL = 8'sd100;
   localparam logic signed [7:0] REWARD_STEP = -8'sd1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_INIT   = 3'd1,
      ST_SELECT = 3'd2,
      ST_MOVE   = 3'd3,
      ST_UPDATE = 3'd4,
      ST_CHECK  = 3'd5,
      ST_DONE   = 3'd6
   } ctrl_state_e;

   // Out-of-range start states fall back to the top-left cell.
   function automatic logic [5:0] sanitize_state(input logic [5:0] s);
      logic [5:0] r;
      if ((s == 6'd0) || (s > 6'(N_STATES))) begin
         r = 6'd1;
      end else begin
         r = s;
      end
      return r;
   endfunction

   function automatic logic lfsr8_feedback(input logic [7:0] v);
      return v[7] ^ v[5] ^ v[4] ^ v[3];
   endfunction

endpackage

// File: rtl/maze_lfsr8.sv
// 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, loaded with SEED on reset.
module maze_lfsr8
   import maze_pkg::*;
#(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_en,
   output logic [7:0] o_lfsr
);

   logic [7:0] r_lfsr;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_lfsr <= SEED;
      end else if (i_en) begin
         r_lfsr <= {r_lfsr[6:0], lfsr8_feedback(r_lfsr)};
      end else begin
         r_lfsr <= r_lfsr;
      end
   end

   assign o_lfsr = r_lfsr;

endmodule

// File: rtl/maze_episode_ctrl.sv
// Episode sequencer for maze Q-learning: epsilon-greedy action choice, selector drive,
// update-tuple handshake, episode/run bookkeeping. All outputs are registered.
module maze_episode_ctrl
   import maze_pkg::*;
#(
   parameter int         MAX_STEPS  = 64,
   parameter int         N_EPISODES = 100,
   parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic [5:0]         i_start_state,
   input  logic [5:0]         i_goal_state,
   input  logic [7:0]         i_explore_thresh,
   input  logic [3:0]         i_q_best_action,
   output logic [5:0]         o_ss_current_state,
   output logic [3:0]         o_ss_action,
   input  logic [5:0]         i_ss_next_state,
   output logic               o_upd_valid,
   input  logic               i_upd_ready,
   output logic [5:0]         o_upd_state,
   output logic [5:0]         o_upd_next_state,
   output logic [3:0]         o_upd_action,
   output logic signed [7:0]  o_upd_reward,
   output logic               o_busy,
   output logic               o_ep_done,
   output logic               o_ep_goal,
   output logic [7:0]         o_ep_steps,
   output logic [15:0]        o_ep_index,
   output logic               o_run_done
);

   localparam logic [7:0]  L_MAX_STEPS  = 8'(MAX_STEPS);
   localparam logic [15:0] L_N_EPISODES = 16'(N_EPISODES);

   ctrl_state_e       r_state;
   ctrl_state_e       w_state_next;

   logic [7:0]        w_lfsr;
   logic              w_explore;
   logic [3:0]        w_act_choice;
   logic              w_handshake;
   logic              w_ep_end;
   logic              w_last_ep;

   logic [5:0]        r_cur_state;
   logic [3:0]        r_act;
   logic [5:0]        r_nxt;
   logic signed [7:0] r_reward;
   logic [7:0]        r_step_cnt;
   logic [15:0]       r_ep_index;
   logic [3:0]        r_ss_action;
   logic              r_upd_valid;
   logic              r_busy;
   logic              r_ep_done;
   logic              r_ep_goal;
   logic [7:0]        r_ep_steps;
   logic              r_run_done;

   maze_lfsr8 #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_en   (1'b1),
      .o_lfsr (w_lfsr)
   );

   assign w_handshake = r_upd_valid && i_upd_ready;
   assign w_ep_end    = (r_cur_state == i_goal_state) || (r_step_cnt == L_MAX_STEPS);
   assign w_last_ep   = ((r_ep_index + 16'd1) == L_N_EPISODES);

   // Epsilon-greedy choice; an invalid Q-table action also forces exploration.
   always_comb begin
      w_explore    = 1'b0;
      w_act_choice = ACT_NONE;
      if ((w_lfsr < i_explore_thresh) || (i_q_best_action == ACT_NONE) ||
          (i_q_best_action > ACT_DOWN)) begin
         w_explore = 1'b1;
      end else begin
         w_explore = 1'b0;
      end
      if (w_explore) begin
         w_act_choice = {2'b00, w_lfsr[1:0]} + 4'd1;
      end else begin
         w_act_choice = i_q_best_action;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (i_start) w_state_next = ST_INIT;
            else         w_state_next = ST_IDLE;
         end
         ST_INIT:   w_state_next = ST_SELECT;
         ST_SELECT: w_state_next = ST_MOVE;
         ST_MOVE:   w_state_next = ST_UPDATE;
         ST_UPDATE: begin
            if (w_handshake) w_state_next = ST_CHECK;
            else             w_state_next = ST_UPDATE;
         end
         ST_CHECK: begin
            if (w_ep_end) begin
               if (w_last_ep) w_state_next = ST_DONE;
               else           w_state_next = ST_INIT;
            end else begin
               w_state_next = ST_SELECT;
            end
         end
         ST_DONE: begin
            if (i_start) w_state_next = ST_INIT;
            else         w_state_next = ST_DONE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Status flags are computed from the next state so they line up with the state itself.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cur_state <= 6'd1;
         r_act       <= ACT_NONE;
         r_nxt       <= 6'd1;
         r_reward    <= REWARD_STEP;
         r_step_cnt  <= 8'd0;
         r_ep_index  <= 16'd0;
         r_ss_action <= ACT_NONE;
         r_upd_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_ep_done   <= 1'b0;
         r_ep_goal   <= 1'b0;
         r_ep_steps  <= 8'd0;
         r_run_done  <= 1'b0;
      end else begin
         r_upd_valid <= (w_state_next == ST_UPDATE);
         r_busy      <= (w_state_next != ST_IDLE) && (w_state_next != ST_DONE);
         r_run_done  <= (w_state_next == ST_DONE);
         r_ss_action <= (w_state_next == ST_MOVE) ? w_act_choice : ACT_NONE;
         r_ep_done   <= 1'b0;
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (i_start) r_ep_index <= 16'd0;
            end
            ST_INIT: begin
               r_cur_state <= sanitize_state(i_start_state);
               r_step_cnt  <= 8'd0;
            end
            ST_SELECT: r_act <= w_act_choice;
            ST_MOVE: begin
               r_nxt    <= i_ss_next_state;
               r_reward <= (i_ss_next_state == i_goal_state) ? REWARD_GOAL : REWARD_STEP;
            end
            ST_UPDATE: begin
               if (w_handshake) begin
                  r_cur_state <= r_nxt;
                  r_step_cnt  <= r_step_cnt + 8'd1;
               end
            end
            ST_CHECK: begin
               if (w_ep_end) begin
                  r_ep_done  <= 1'b1;
                  r_ep_goal  <= (r_cur_state == i_goal_state);
                  r_ep_steps <= r_step_cnt;
                  r_ep_index <= r_ep_index + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_ss_current_state = r_cur_state;
   assign o_ss_action        = r_ss_action;
   assign o_upd_valid        = r_upd_valid;
   assign o_upd_state        = r_cur_state;
   assign o_upd_next_state   = r_nxt;
   assign o_upd_action       = r_act;
   assign o_upd_reward       = r_reward;
   assign o_busy             = r_busy;
   assign o_ep_done          = r_ep_done;
   assign o_ep_goal          = r_ep_goal;
   assign o_ep_steps         = r_ep_steps;
   assign o_ep_index         = r_ep_index;
   assign o_run_done         = r_run_done;

endmodule
